// File: rtl/ball_collision_detect.sv
// Pong collision/score sequencer: wall and paddle bounce strobes, miss detection,
// per-player scoring and the SERVE/PLAY/OVER sequencing, all evaluated on sample_en.
module ball_collision_detect #(
  parameter int unsigned x_coords_width = 10,
  parameter int unsigned y_coords_width = 10,
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned STEP           = 10,
  parameter int unsigned BALL_SIZE      = 8,
  parameter int unsigned PADDLE_W       = 8,
  parameter int unsigned PADDLE_H       = 64,
  parameter int unsigned PADDLE_L_X     = 16,
  parameter int unsigned PADDLE_R_X     = 616,
  parameter int unsigned HOLDOFF        = 4,
  parameter int unsigned SERVE_WAIT     = 60,
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned WIN_SCORE      = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_en,
  input  logic [x_coords_width-1:0] ball_x,
  input  logic [y_coords_width-1:0] ball_y,
  input  logic [y_coords_width-1:0] paddle_l_y,
  input  logic [y_coords_width-1:0] paddle_r_y,
  output logic                      touching_paddle,
  output logic                      touching_wall,
  output logic                      point_l,
  output logic                      point_r,
  output logic                      serve_req,
  output logic [SCORE_W-1:0]        score_l,
  output logic [SCORE_W-1:0]        score_r,
  output logic                      game_over
);

  localparam int unsigned XW1    = x_coords_width + 1;
  localparam int unsigned YW1    = y_coords_width + 1;
  localparam int unsigned HOLD_W = $clog2(HOLDOFF + 1);
  localparam int unsigned WAIT_W = $clog2(SERVE_WAIT + 1);

  typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_OVER} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [HOLD_W-1:0]   hold_w_q, hold_w_d, hold_p_q, hold_p_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic                tp_q, tp_d, tw_q, tw_d, pl_q, pl_d, pr_q, pr_d;
  logic                serve_q, serve_d, over_q, over_d;

  // Geometry in width+1 bits so additions never wrap
  logic [XW1-1:0] bx;
  logic [YW1-1:0] by, ply, pry;
  logic           wall_hit, lhit, rhit, paddle_hit, miss_l, miss_r, x_wrap, y_wrap;

  function automatic logic overlap(input logic [YW1-1:0] y, input logic [YW1-1:0] p);
    return ((y + YW1'(BALL_SIZE)) > p) && (y < (p + YW1'(PADDLE_H)));
  endfunction

  always_comb begin
    bx         = XW1'(ball_x);
    by         = YW1'(ball_y);
    ply        = YW1'(paddle_l_y);
    pry        = YW1'(paddle_r_y);
    x_wrap     = bx >= XW1'((1 << x_coords_width) - STEP);
    y_wrap     = by >= YW1'((1 << y_coords_width) - STEP);
    wall_hit   = (by < YW1'(STEP)) || y_wrap ||
                 ((by >= YW1'(SCREEN_H - BALL_SIZE)) && !y_wrap);
    lhit       = (bx < XW1'(PADDLE_L_X + PADDLE_W)) &&
                 ((bx + XW1'(BALL_SIZE)) > XW1'(PADDLE_L_X)) && overlap(by, ply);
    rhit       = (bx < XW1'(PADDLE_R_X + PADDLE_W)) &&
                 ((bx + XW1'(BALL_SIZE)) > XW1'(PADDLE_R_X)) && overlap(by, pry);
    paddle_hit = lhit || rhit;
    miss_l     = ((bx < XW1'(STEP)) || x_wrap) && !paddle_hit;
    miss_r     = (bx >= XW1'(SCREEN_W - BALL_SIZE)) && !x_wrap && !paddle_hit;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    hold_w_d  = hold_w_q;
    hold_p_d  = hold_p_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    over_d    = over_q;
    tp_d      = 1'b0;
    tw_d      = 1'b0;
    pl_d      = 1'b0;
    pr_d      = 1'b0;
    serve_d   = 1'b0;
    if (sample_en) begin
      if (hold_w_q != '0) hold_w_d = hold_w_q - 1'b1;
      if (hold_p_q != '0) hold_p_d = hold_p_q - 1'b1;
      case (state_q)
        ST_SERVE: begin
          if (wait_q == WAIT_W'(SERVE_WAIT - 1)) begin
            serve_d  = 1'b1;
            wait_d   = '0;
            hold_w_d = '0;
            hold_p_d = '0;
            state_d  = ST_PLAY;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_PLAY: begin
          if (miss_l) begin
            pr_d      = 1'b1;
            score_r_d = score_r_q + 1'b1;
            wait_d    = '0;
            state_d   = (score_r_d == SCORE_W'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
            over_d    = (score_r_d == SCORE_W'(WIN_SCORE));
          end else if (miss_r) begin
            pl_d      = 1'b1;
            score_l_d = score_l_q + 1'b1;
            wait_d    = '0;
            state_d   = (score_l_d == SCORE_W'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
            over_d    = (score_l_d == SCORE_W'(WIN_SCORE));
          end else begin
            if (wall_hit && (hold_w_q == '0)) begin
              tw_d     = 1'b1;
              hold_w_d = HOLD_W'(HOLDOFF);
            end
            if (paddle_hit && (hold_p_q == '0)) begin
              tp_d     = 1'b1;
              hold_p_d = HOLD_W'(HOLDOFF);
            end
          end
        end
        ST_OVER: ;
        default: state_d = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_SERVE;
      wait_q    <= '0;
      hold_w_q  <= '0;
      hold_p_q  <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      over_q    <= 1'b0;
      tp_q      <= 1'b0;
      tw_q      <= 1'b0;
      pl_q      <= 1'b0;
      pr_q      <= 1'b0;
      serve_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      hold_w_q  <= hold_w_d;
      hold_p_q  <= hold_p_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      over_q    <= over_d;
      tp_q      <= tp_d;
      tw_q      <= tw_d;
      pl_q      <= pl_d;
      pr_q      <= pr_d;
      serve_q   <= serve_d;
    end
  end

  assign touching_paddle = tp_q;
  assign touching_wall   = tw_q;
  assign point_l         = pl_q;
  assign point_r         = pr_q;
  assign serve_req       = serve_q;
  assign score_l         = score_l_q;
  assign score_r         = score_r_q;
  assign game_over       = over_q;

endmodule

// File: tb/tb_ball_collision_detect.sv
// Scoreboard bench for ball_collision_detect: randomized samples against a behavioural
// game model; a monitor compares every post-sample output cycle against the queue.
`timescale 1ns/1ps
module tb_ball_collision_detect;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic [9:0] ball_x = '0, ball_y = '0, paddle_l_y = '0, paddle_r_y = '0;
  logic       touching_paddle, touching_wall, point_l, point_r, serve_req, game_over;
  logic [3:0] score_l, score_r;

  typedef struct packed {
    logic       tp;
    logic       tw;
    logic       pl;
    logic       pr;
    logic       sv;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  logic samp_d;

  // Behavioural game state: 0 serving, 1 in play, 2 game finished
  int m_mode, m_wait, m_hw, m_hp, m_sl, m_sr;

  ball_collision_detect dut (
    .clk(clk), .reset(reset), .sample_en(sample_en),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .touching_paddle(touching_paddle), .touching_wall(touching_wall),
    .point_l(point_l), .point_r(point_r), .serve_req(serve_req),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.tp = touching_paddle; o.tw = touching_wall; o.pl = point_l; o.pr = point_r;
    o.sv = serve_req; o.sl = score_l; o.sr = score_r; o.go = game_over;
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_hw = 0; m_hp = 0; m_sl = 0; m_sr = 0;
  endtask

  function automatic bit ovl(input int y, input int p);
    return (y + 8 > p) && (y < p + 64);
  endfunction

  // One sample of the game rules, computed with plain integer arithmetic
  task automatic model_step(input int bx, input int by, input int pl, input int pr,
                            output obs_t e);
    bit wall, hit, missl, missr, hw_busy, hp_busy;
    e = '0;
    hw_busy = (m_hw > 0);
    hp_busy = (m_hp > 0);
    if (m_hw > 0) m_hw--;
    if (m_hp > 0) m_hp--;
    wall  = (by < 10) || (by >= 1014) || ((by >= 472) && !(by >= 1014));
    hit   = ((bx < 24) && (bx + 8 > 16) && ovl(by, pl)) ||
            ((bx < 624) && (bx + 8 > 616) && ovl(by, pr));
    missl = ((bx < 10) || (bx >= 1014)) && !hit;
    missr = (bx >= 632) && (bx < 1014) && !hit;
    if (m_mode == 0) begin
      m_wait++;
      if (m_wait == 60) begin
        e.sv = 1'b1; m_wait = 0; m_hw = 0; m_hp = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (missl) begin
        m_sr++; e.pr = 1'b1; m_mode = (m_sr == 9) ? 2 : 0; m_wait = 0;
      end else if (missr) begin
        m_sl++; e.pl = 1'b1; m_mode = (m_sl == 9) ? 2 : 0; m_wait = 0;
      end else begin
        if (wall && !hw_busy) begin e.tw = 1'b1; m_hw = 4; end
        if (hit && !hp_busy)  begin e.tp = 1'b1; m_hp = 4; end
      end
    end
    e.sl = 4'(m_sl);
    e.sr = 4'(m_sr);
    e.go = (m_mode == 2);
  endtask

  task automatic do_sample(input int bx, input int by, input int pl, input int pr);
    obs_t e;
    @(negedge clk);
    ball_x = 10'(bx); ball_y = 10'(by); paddle_l_y = 10'(pl); paddle_r_y = 10'(pr);
    sample_en = 1'b1;
    model_step(bx, by, pl, pr, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    sample_en = 1'b0;
    for (int i = 1; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_en = 1'b0;
    #2 reset = 1'b0;
    #1 check("reset_outputs", 32'(observe()), 32'(obs_t'('0)));
    check("reset_queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check("reset_held", 32'(observe()), 32'(obs_t'('0)));
    reset = 1'b1;
  endtask

  task automatic rand_sample();
    int bx, by;
    case ($urandom_range(0, 4))
      0:       bx = $urandom_range(0, 1023);
      1:       bx = $urandom_range(0, 40);
      2:       bx = $urandom_range(600, 645);
      3:       bx = $urandom_range(1008, 1023);
      default: bx = $urandom_range(100, 500);
    endcase
    by = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
    do_sample(bx, by, $urandom_range(0, 416), $urandom_range(0, 416));
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  always @(posedge clk or negedge reset)
    if (!reset) samp_d <= 1'b0;
    else        samp_d <= sample_en;

  // Monitor: each cycle following a sample carries one expected response
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (samp_d) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sample_response", 32'(observe()), 32'(e));
        end
      end else if (reset) begin
        check("idle_no_strobe",
              32'({touching_paddle, touching_wall, point_l, point_r, serve_req}), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    for (int i = 0; i < 60; i++) do_sample(320, 240, 200, 200);
    for (int i = 0; i < 6; i++) do_sample(320, 2, 200, 200);
    do_sample(20, 100, 80, 200);
    for (int i = 0; i < 4; i++) do_sample(320, 240, 200, 200);
    do_sample(20, 2, 0, 200);
    do_sample(20, 100, 80, 200);
    do_reset();
    for (int i = 0; i < 60; i++) do_sample(320, 240, 200, 200);
    do_sample(1020, 240, 300, 200);
    do_sample(320, 2, 200, 200);
    idle(2);
    for (int i = 0; i < 400; i++) rand_sample();
    for (int k = 0; k < 2000 && m_mode != 2; k++) begin
      if (m_mode == 1) do_sample(3, 240, 400, 200);
      else             do_sample(320, 240, 200, 200);
    end
    for (int i = 0; i < 20; i++) do_sample(3, 240, 400, 200);
    for (int i = 0; i < 20; i++) rand_sample();
    idle(3);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_game_over", 32'(game_over), 32'd1);
    check("final_scores", 32'({score_l, score_r}), 32'({4'(m_sl), 4'(m_sr)}));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
